// File: rtl/unified_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : unified_mem_arbiter_pkg
// Brief   : Shared states and constants for the unified memory arbiter.
// Revision: 1.0
// ============================================================================
package unified_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_I_REQ  = 3'd1,
        ST_I_WAIT = 3'd2,
        ST_D_REQ  = 3'd3,
        ST_D_WAIT = 3'd4
    } arb_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          TIMEOUT_W = 8;

endpackage
`default_nettype wire

// File: rtl/unified_mem_arbiter_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module  : arb_timeout_ctr
// Brief   : Per-state cycle counter with terminal-count flag for abort.
// Revision: 1.0
// ============================================================================
module arb_timeout_ctr
    import unified_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [TIMEOUT_W-1:0] TC_VAL = TIMEOUT_W'(TIMEOUT_CYC - 1);

    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires during the TIMEOUT_CYC-th cycle spent in the current state.
    assign tc_o = en_i && (cnt_q == TC_VAL);

endmodule
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : unified_mem_arbiter
// Brief   : Shares one single-port memory between IF fetch and MEM data ports.
// Revision: 1.0
// ============================================================================
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    arb_state_t        state_q, state_d;
    logic              drop_q, drop_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              d_valid_q, d_valid_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              err_q, err_d;
    logic              tmo_tc;
    logic              fetch_squashed;

    arb_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear_i (state_d != state_q),
        .en_i    (state_q != ST_IDLE),
        .tc_o    (tmo_tc)
    );

    // A flush arriving in the same cycle as the response still squashes it.
    assign fetch_squashed = drop_q || if_flush;

    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        if_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_valid_d   = 1'b0;
        d_rdata_d   = d_rdata_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                // A port still showing its valid pulse has not yet lowered its req.
                if (d_req && !d_valid_q) begin
                    state_d     = ST_D_REQ;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_wstrb_d = d_wstrb;
                end else if (if_req && !if_flush && !if_valid_q) begin
                    state_d     = ST_I_REQ;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_wstrb_d = 4'b0000;
                end
            end

            ST_I_REQ: begin
                if (if_flush) begin
                    drop_d = 1'b1;
                end
                if (mem_gnt) begin
                    state_d   = ST_I_WAIT;
                    mem_req_d = 1'b0;
                end else if (tmo_tc) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    drop_d    = 1'b0;
                    if (!fetch_squashed) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = DATA_W'(NOP_INSTR);
                    end
                end
            end

            ST_I_WAIT: begin
                if (if_flush) begin
                    drop_d = 1'b1;
                end
                if (mem_rvalid || tmo_tc) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                    err_d   = err_q || !mem_rvalid;
                    if (!fetch_squashed) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rvalid ? mem_rdata : DATA_W'(NOP_INSTR);
                    end
                end
            end

            ST_D_REQ: begin
                if (mem_gnt) begin
                    state_d   = ST_D_WAIT;
                    mem_req_d = 1'b0;
                end else if (tmo_tc) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    d_valid_d = 1'b1;
                    d_rdata_d = '0;
                end
            end

            ST_D_WAIT: begin
                if (mem_rvalid || tmo_tc) begin
                    state_d   = ST_IDLE;
                    err_d     = err_q || !mem_rvalid;
                    d_valid_d = 1'b1;
                    d_rdata_d = mem_rvalid ? mem_rdata : '0;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            drop_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= 4'b0000;
            if_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_valid_q   <= 1'b0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if_valid_q  <= if_valid_d;
            if_rdata_q  <= if_rdata_d;
            d_valid_q   <= d_valid_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
        end
    end

    assign if_valid  = if_valid_q;
    assign if_rdata  = if_rdata_q;
    assign d_valid   = d_valid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign err       = err_q;
    assign stall_if  = if_req && !if_valid_q;
    assign stall_mem = d_req && !d_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_unified_mem_arbiter
// Brief   : Directed scoreboard bench for the unified memory arbiter.
// Revision: 1.0
// ============================================================================
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_flush, if_valid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_valid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic        stall_if, stall_mem;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        err;

    int checks = 0;
    int errors = 0;
    int d_pulses = 0;
    int i_pulses = 0;
    logic [31:0] sb_d[$];
    logic [31:0] sb_i[$];

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_flush   (if_flush),
        .if_valid   (if_valid),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_wstrb    (d_wstrb),
        .d_valid    (d_valid),
        .d_rdata    (d_rdata),
        .stall_if   (stall_if),
        .stall_mem  (stall_mem),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Every valid pulse must match the oldest expected response of its port.
    always @(negedge clk) begin
        if (reset) begin
            if (d_valid) begin
                d_pulses++;
                chk("d_rdata", d_rdata, (sb_d.size() != 0) ? sb_d.pop_front() : 32'hxxxx_xxxx);
            end
            if (if_valid) begin
                i_pulses++;
                chk("if_rdata", if_rdata, (sb_i.size() != 0) ? sb_i.pop_front() : 32'hxxxx_xxxx);
            end
        end
    end

    initial begin
        int d_base;
        reset = 1'b0;
        if_req = 0; if_addr = '0; if_flush = 0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;

        // Reset state
        #2;
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_valids", {30'b0, if_valid, d_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        mid();
        reset = 1'b1;
        next();

        // Single load: d_req@0, gnt@1, rvalid@2, d_valid@3
        d_req = 1; d_addr = 32'h100;
        mid();
        chk("ld_stall0", {31'b0, stall_mem}, 32'd1);
        chk("ld_memreq0", {31'b0, mem_req}, 32'd0);
        next();
        mem_gnt = 1;
        mid();
        chk("ld_memreq1", {31'b0, mem_req}, 32'd1);
        chk("ld_addr1", mem_addr, 32'h100);
        chk("ld_we1", {31'b0, mem_we}, 32'd0);
        next();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        sb_d.push_back(32'hDEAD_BEEF);
        mid();
        chk("ld_memreq2", {31'b0, mem_req}, 32'd0);
        chk("ld_stall2", {31'b0, stall_mem}, 32'd1);
        chk("ld_dvalid2", {31'b0, d_valid}, 32'd0);
        next();
        mem_rvalid = 0;
        mid();
        chk("ld_dvalid3", {31'b0, d_valid}, 32'd1);
        chk("ld_stall3", {31'b0, stall_mem}, 32'd0);
        next();
        d_req = 0;
        mid();
        chk("ld_norelaunch", {31'b0, mem_req}, 32'd0);
        next();

        // Contention: data served first, fetch launches right after d_valid
        if_req = 1; if_addr = 32'h200; d_req = 1; d_addr = 32'h300;
        next();
        mem_gnt = 1;
        mid();
        chk("ct_addr_data", mem_addr, 32'h300);
        next();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1111_2222;
        sb_d.push_back(32'h1111_2222);
        next();
        mem_rvalid = 0;
        mid();
        chk("ct_dvalid", {31'b0, d_valid}, 32'd1);
        chk("ct_memreq_hold", {31'b0, mem_req}, 32'd0);
        chk("ct_stall_if", {31'b0, stall_if}, 32'd1);
        next();
        d_req = 0; mem_gnt = 1;
        mid();
        chk("ct_fetch_req", {31'b0, mem_req}, 32'd1);
        chk("ct_fetch_addr", mem_addr, 32'h200);
        next();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h00A0_0093;
        sb_i.push_back(32'h00A0_0093);
        next();
        mem_rvalid = 0;
        mid();
        chk("ct_ifvalid", {31'b0, if_valid}, 32'd1);
        chk("ct_stall_if_done", {31'b0, stall_if}, 32'd0);
        next();
        if_req = 0;
        next();

        // Flush: granted @1, flush @2, rvalid @3 -> response dropped
        if_req = 1; if_addr = 32'h400;
        next();
        mem_gnt = 1;
        mid();
        chk("fl_addr", mem_addr, 32'h400);
        next();
        mem_gnt = 0; if_flush = 1;
        next();
        if_flush = 0; if_req = 0; mem_rvalid = 1; mem_rdata = 32'hBADB_AD00;
        next();
        mem_rvalid = 0; if_req = 1; if_addr = 32'h500;
        mid();
        chk("fl_no_ifvalid", {31'b0, if_valid}, 32'd0);
        next();
        mem_gnt = 1;
        mid();
        chk("fl_next_req", {31'b0, mem_req}, 32'd1);
        chk("fl_next_addr", mem_addr, 32'h500);
        next();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        sb_i.push_back(32'h1234_5678);
        next();
        mem_rvalid = 0;
        mid();
        chk("fl_next_valid", {31'b0, if_valid}, 32'd1);
        next();
        if_req = 0;
        next();

        // Slow memory store: grant 5 cycles late, response 3 cycles later
        d_base = d_pulses;
        d_req = 1; d_we = 1; d_addr = 32'h600; d_wdata = 32'hCAFE_F00D; d_wstrb = 4'b0011;
        next();
        for (int c = 0; c < 5; c++) begin
            mid();
            chk("sl_req", {31'b0, mem_req}, 32'd1);
            chk("sl_payload", {mem_wstrb, mem_we, mem_addr[26:0]}, {4'b0011, 1'b1, 27'h600});
            chk("sl_wdata", mem_wdata, 32'hCAFE_F00D);
            next();
        end
        mem_gnt = 1;
        next();
        mem_gnt = 0;
        next();
        next();
        mem_rvalid = 1; mem_rdata = 32'h0000_0077;
        sb_d.push_back(32'h0000_0077);
        next();
        mem_rvalid = 0;
        mid();
        chk("sl_dvalid", {31'b0, d_valid}, 32'd1);
        next();
        d_req = 0; d_we = 0;
        next();
        next();
        chk("sl_one_pulse", d_pulses - d_base, 32'd1);
        chk("sl_err", {31'b0, err}, 32'd0);

        // Timeout: no grant for 8 cycles in I_REQ
        if_req = 1; if_addr = 32'h700;
        sb_i.push_back(32'h0000_0013);
        next();
        for (int c = 0; c < 8; c++) begin
            mid();
            chk("to_pending_err", {31'b0, err}, 32'd0);
            chk("to_pending_req", {31'b0, mem_req}, 32'd1);
            next();
        end
        mid();
        chk("to_err", {31'b0, err}, 32'd1);
        chk("to_ifvalid", {31'b0, if_valid}, 32'd1);
        chk("to_req_drop", {31'b0, mem_req}, 32'd0);
        next();
        if_req = 0;
        mid();
        chk("to_err_sticky", {31'b0, err}, 32'd1);
        next();

        // Back in IDLE: a data access launches; async reset while in D_WAIT
        d_req = 1; d_addr = 32'h800;
        next();
        mem_gnt = 1;
        mid();
        chk("rs_launch", mem_addr, 32'h800);
        next();
        mem_gnt = 0;
        #2;
        reset = 1'b0;
        #1;
        chk("rs_err", {31'b0, err}, 32'd0);
        chk("rs_ifrdata", if_rdata, 32'd0);
        chk("rs_drdata", d_rdata, 32'd0);
        chk("rs_mem_addr", mem_addr, 32'd0);
        chk("rs_mem_req", {31'b0, mem_req}, 32'd0);
        d_req = 0;
        mid();
        reset = 1'b1;
        next();
        mem_rvalid = 1; mem_rdata = 32'h0000_0099;
        next();
        mem_rvalid = 0;
        mid();
        chk("rs_late_rvalid", {30'b0, d_valid, if_valid}, 32'd0);
        chk("rs_idle", {31'b0, mem_req}, 32'd0);
        next();

        chk("sb_d_empty", sb_d.size(), 32'd0);
        chk("sb_i_empty", sb_i.size(), 32'd0);
        chk("i_pulse_total", i_pulses, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
